// File: rtl/ag_telemetry_uart.sv
// rtl/ag_telemetry_uart.sv - periodic / on-change 5-byte 8N1 telemetry frame transmitter
module ag_telemetry_uart #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FRAME_PERIOD = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sensor_byte,
    input  logic [7:0] actuator_byte,
    input  logic [1:0] crop_select,
    output logic       uart_tx,
    output logic       busy,
    output logic [3:0] seq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(FRAME_PERIOD);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   bit_cnt, bit_cnt_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [2:0]      byte_idx, byte_idx_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            pending, pending_nx;
    logic [7:0]      last_act, last_act_nx;
    logic [7:0]      snap_sensor, snap_sensor_nx;
    logic [7:0]      snap_act, snap_act_nx;
    logic [1:0]      snap_crop, snap_crop_nx;
    logic [3:0]      snap_seq, snap_seq_nx;
    logic            tx_q, tx_nx;
    logic            busy_q, busy_nx;
    logic [3:0]      seq_q, seq_nx;
    logic [7:0]      cur_byte;
    logic [2:0]      next_bit;
    logic            launch, wrap, change, bit_done;

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = snap_sensor;
            3'd2:    cur_byte = snap_act;
            3'd3:    cur_byte = {snap_seq, 2'b00, snap_crop};
            default: cur_byte = 8'hA5 ^ snap_sensor ^ snap_act ^ {snap_seq, 2'b00, snap_crop};
        endcase
    end

    always_comb begin
        state_nx       = state;
        bit_cnt_nx     = bit_cnt;
        bit_idx_nx     = bit_idx;
        byte_idx_nx    = byte_idx;
        last_act_nx    = last_act;
        snap_sensor_nx = snap_sensor;
        snap_act_nx    = snap_act;
        snap_crop_nx   = snap_crop;
        snap_seq_nx    = snap_seq;
        tx_nx          = tx_q;
        busy_nx        = busy_q;
        seq_nx         = seq_q;
        next_bit       = bit_idx + 3'd1;

        wrap     = (timer == TIMER_LAST);
        timer_nx = wrap ? '0 : timer + TW'(1);
        launch   = (state == IDLE) && pending;
        // The launch cycle reloads last_act with the current byte, so it cannot count as a change.
        change   = !launch && (actuator_byte != last_act);
        bit_done = (bit_cnt == BIT_LAST);
        if (state != IDLE) begin
            bit_cnt_nx = bit_done ? '0 : bit_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (pending) begin
                    snap_sensor_nx = sensor_byte;
                    snap_act_nx    = actuator_byte;
                    snap_crop_nx   = crop_select;
                    snap_seq_nx    = seq_q;
                    last_act_nx    = actuator_byte;
                    state_nx       = START;
                    tx_nx          = 1'b0;
                    busy_nx        = 1'b1;
                    bit_cnt_nx     = '0;
                    bit_idx_nx     = 3'd0;
                    byte_idx_nx    = 3'd0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nx   = DATA;
                    bit_idx_nx = 3'd0;
                    tx_nx      = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = next_bit;
                        tx_nx      = cur_byte[next_bit];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx < 3'd4) begin
                        byte_idx_nx = byte_idx + 3'd1;
                        state_nx    = START;
                        tx_nx       = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        seq_nx   = seq_q + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        pending_nx = (launch ? 1'b0 : pending) | wrap | change;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= 3'd0;
            byte_idx    <= 3'd0;
            timer       <= '0;
            pending     <= 1'b0;
            last_act    <= 8'h00;
            snap_sensor <= 8'h00;
            snap_act    <= 8'h00;
            snap_crop   <= 2'b00;
            snap_seq    <= 4'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            seq_q       <= 4'd0;
        end else if (ena) begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            bit_idx     <= bit_idx_nx;
            byte_idx    <= byte_idx_nx;
            timer       <= timer_nx;
            pending     <= pending_nx;
            last_act    <= last_act_nx;
            snap_sensor <= snap_sensor_nx;
            snap_act    <= snap_act_nx;
            snap_crop   <= snap_crop_nx;
            snap_seq    <= snap_seq_nx;
            tx_q        <= tx_nx;
            busy_q      <= busy_nx;
            seq_q       <= seq_nx;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign seq     = seq_q;

endmodule

// File: tb/tb_ag_telemetry_uart.sv
// tb/tb_ag_telemetry_uart.sv - scoreboard bench for ag_telemetry_uart
module tb_ag_telemetry_uart;

    localparam int CPB  = 4;
    localparam int FP   = 400;
    localparam int FLEN = 50 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] sensor_byte = 8'h9E;
    logic [7:0] actuator_byte = 8'h00;
    logic [1:0] crop_select = 2'b00;
    logic       uart_tx;
    logic       busy;
    logic [3:0] seq;

    always #5 clk = ~clk;

    ag_telemetry_uart #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(FP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .sensor_byte(sensor_byte), .actuator_byte(actuator_byte), .crop_select(crop_select),
        .uart_tx(uart_tx), .busy(busy), .seq(seq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the frame scheduler; expected bytes go to the scoreboard queue at launch.
    logic [7:0]  exp_q[$];
    int          m_timer, m_pos;
    bit          m_pend, m_busy, m_tx;
    logic [7:0]  m_last;
    logic [3:0]  m_seq;
    logic [49:0] m_bits;
    logic [7:0]  m_b[5];
    bit          launch, wrap, chg;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_timer = 0; m_pos = 0; m_pend = 0; m_busy = 0; m_tx = 1;
            m_last = 8'h00; m_seq = 4'd0;
            exp_q.delete();
        end else if (ena) begin
            launch  = !m_busy && m_pend;
            wrap    = (m_timer == FP - 1);
            chg     = !launch && (actuator_byte != m_last);
            m_timer = wrap ? 0 : m_timer + 1;
            if (m_busy) begin
                m_pos++;
                if (m_pos == FLEN) begin
                    m_busy = 0; m_tx = 1; m_seq = m_seq + 4'd1;
                end else begin
                    m_tx = m_bits[m_pos / CPB];
                end
            end
            if (launch) begin
                m_b[0] = 8'hA5;
                m_b[1] = sensor_byte;
                m_b[2] = actuator_byte;
                m_b[3] = {m_seq, 2'b00, crop_select};
                m_b[4] = m_b[0] ^ m_b[1] ^ m_b[2] ^ m_b[3];
                for (int j = 0; j < 5; j++) begin
                    exp_q.push_back(m_b[j]);
                    m_bits[j*10] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[j*10+1+i] = m_b[j][i];
                    m_bits[j*10+9] = 1'b1;
                end
                m_busy = 1; m_pos = 0; m_tx = 0; m_last = actuator_byte; m_pend = 0;
            end
            if (wrap || chg) m_pend = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("tx_level", uart_tx, m_tx);
            check_eq("busy", busy, m_busy);
            check_eq("seq", seq, m_seq);
        end
    end

    // Independent UART receiver: samples mid-bit, counting only enabled cycles.
    logic       ena_q = 1'b0, rst_q = 1'b0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte;
    logic [7:0] rx_log[$];

    always @(posedge clk) begin
        ena_q <= ena;
        rst_q <= rst_n;
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            rx_busy = 0;
        end else if (ena_q) begin
            if (!rx_busy) begin
                if (uart_tx === 1'b0) begin
                    rx_busy = 1; rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_busy && (rx_cnt % CPB == CPB / 2)) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                    rx_byte[rx_cnt / CPB - 1] = uart_tx;
                end else if (rx_cnt / CPB == 9) begin
                    check_eq("rx_stop", uart_tx, 1'b1);
                    rx_log.push_back(rx_byte);
                    if (exp_q.size() > 0) check_eq("sb_byte", rx_byte, exp_q.pop_front());
                    else check_eq("sb_unexpected", {24'd0, rx_byte}, 32'h1FF);
                    rx_busy = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_busy(input logic val, input int max, output int cyc);
        cyc = 0;
        while (busy !== val && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        if (busy !== val) check_eq("busy_timeout", busy, val);
    endtask

    task automatic check_frame(input string tag, input logic [39:0] exp);
        check_eq({tag, "_len"}, rx_log.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq(tag, (i < rx_log.size()) ? {24'd0, rx_log[i]} : 32'hFFFF, {24'd0, exp[39-8*i -: 8]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, bad;
        logic held;

        // Reset state and first periodic frame
        step(2);
        chk_en = 1'b1;
        check_eq("rst_tx", uart_tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_seq", seq, 4'd0);
        rst_n = 1'b1;
        wait_busy(1'b1, 1000, c);
        check_eq("t1_launch_cycle", c, 401);
        rx_log.delete();
        wait_busy(1'b0, 400, c);
        check_eq("t1_busy_len", c, FLEN);
        check_eq("t1_seq", seq, 4'd1);
        check_frame("t1_frame", 40'hA5_9E_00_00_3B);

        // Actuator change trigger, then mid-frame change
        do_reset();
        actuator_byte = 8'h05;
        crop_select   = 2'b10;
        wait_busy(1'b1, 10, c);
        check_eq("t2_launch_lat", c, 2);
        rx_log.delete();
        step(100);
        actuator_byte = 8'h07;
        wait_busy(1'b0, 400, c);
        check_eq("t2_busy_len", 100 + c, FLEN);
        check_frame("t2_frame", 40'hA5_9E_05_02_3C);
        rx_log.delete();
        wait_busy(1'b1, 10, c);
        check_eq("t3_idle_gap", c, 1);
        wait_busy(1'b0, 400, c);
        check_frame("t3_frame", 40'hA5_9E_07_12_2E);

        // Wrap and actuator change in the same cycle
        actuator_byte = 8'h00;
        crop_select   = 2'b00;
        do_reset();
        step(399);
        actuator_byte = 8'h11;
        wait_busy(1'b1, 5, c);
        check_eq("t4_launch_lat", c, 2);
        wait_busy(1'b0, 400, c);
        check_eq("t4_busy_len", c, FLEN);
        step(150);
        check_eq("t4_single_frame", busy, 1'b0);

        // ena freeze mid-frame
        actuator_byte = 8'h00;
        do_reset();
        actuator_byte = 8'h05;
        crop_select   = 2'b10;
        wait_busy(1'b1, 10, c);
        rx_log.delete();
        step(50);
        held = uart_tx;
        ena  = 1'b0;
        bad  = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            if (uart_tx !== held) bad++;
        end
        check_eq("t5_frozen_tx", bad, 0);
        ena = 1'b1;
        wait_busy(1'b0, 400, c);
        check_eq("t5_stretched_len", 50 + 37 + c, FLEN + 37);
        check_frame("t5_frame", 40'hA5_9E_05_02_3C);

        // Reset during byte 2
        actuator_byte = 8'h00;
        do_reset();
        actuator_byte = 8'h05;
        wait_busy(1'b1, 10, c);
        step(100);
        rst_n = 1'b0;
        actuator_byte = 8'h00;
        step(1);
        check_eq("t6_abort_tx", uart_tx, 1'b1);
        check_eq("t6_abort_busy", busy, 1'b0);
        check_eq("t6_abort_seq", seq, 4'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("t6_quiet", bad, 0);

        // Seventeen periodic frames: seq wraps 15 -> 0
        crop_select = 2'b00;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            wait_busy(1'b1, 500, c);
            rx_log.delete();
            wait_busy(1'b0, 400, c2);
            check_eq("t7_seq", seq, k % 16);
            check_eq("t7_b3_seq", (rx_log.size() == 5) ? {28'd0, rx_log[3][7:4]} : 32'hFF, (k - 1) % 16);
        end

        step(10);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
